us_dma_chan_mux: RTL and testbench
==================================

Name: us_dma_chan_mux

Overview:
- Parametrised upstream (board-to-host) DMA data mux.
- Moves a programmed byte count from one of NUM_CH first-word-fall-through channel FIFOs into the shared PCIe write FIFO.
- The channel is selected by the upstream DMA physical-address tag.
- Also generates per-channel data-ready and timeout interrupts.
- Sits between the per-channel DDR3 read FIFOs and the PCIe DMA engine; replaces the fixed two-channel upstream path.

Parameters:
- NUM_CH, 4, number of channels (1..15).
- DATA_W, 64, FIFO data width in bits (power of two, >= 8).
- TOUT_VAL, 250_000_000, timeout threshold in user_clk cycles (2 s at 125 MHz).
- CH_W, 4, width of the active-channel index.

Ports:
- user_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- dma_us_busy  in  1  upstream DMA in progress.
- dma_us_pa  in  32  upstream DMA physical address; bits [31:28] are the channel tag (tag k selects channel k-1).
- ch_dmasize  in  NUM_CH*32  per-channel transfer size in bytes; lane i is [32i+:32].
- ch_enable  in  NUM_CH  channel run bit.
- ch_ds_mode  in  NUM_CH  1 = channel is in downstream mode; upstream transfers are blocked.
- ch_valid  in  NUM_CH  channel has a DMA block ready.
- int_en_data  in  NUM_CH  data interrupt enable.
- int_en_tout  in  NUM_CH  timeout interrupt enable.
- int_en_tout_all  in  1  combined timeout interrupt enable.
- ch_rd_data  in  NUM_CH*DATA_W  FWFT channel FIFO data.
- ch_rd_empty  in  NUM_CH  channel FIFO empty.
- ch_rd_en  out  NUM_CH  channel FIFO pop.
- ch_rd_dma  out  NUM_CH  channel currently owns the upstream DMA.
- fifo_wr_full  in  1  PCIe write FIFO full; must assert with at least 1 word of slack.
- fifo_wr_en  out  1  PCIe FIFO write.
- fifo_wr_din  out  DATA_W  PCIe FIFO data.
- ch_irq  out  NUM_CH  data-ready interrupt.
- ch_tout_irq  out  NUM_CH  timeout interrupt.
- any_irq  out  1  OR of ch_irq.
- tout_all_irq  out  1  combined timeout interrupt.
- active_ch  out  CH_W  latched channel index.
- xfer_count  out  32  words moved in the current transfer.
- xfer_done  out  1  one-cycle pulse on transfer completion.

Behaviour:
- Reset: every output, state and counter is 0; state is IDLE.
- Word size: WB = DATA_W/8 bytes. Target = dmasize >> log2(WB), truncating; a partial word is not transferred.
- FSM states: IDLE, XFER, DONE.
  - IDLE -> XFER when dma_us_busy=1, tag t is in 1..NUM_CH, and ch_ds_mode[t-1]=0. On this transition latch active_ch=t-1, latch target, clear xfer_count.
  - IDLE -> DONE instead of XFER if the latched target is 0; xfer_done pulses.
  - A tag of 0, a tag > NUM_CH, or a downstream-mode channel leaves the FSM in IDLE; no pops occur.
  - XFER: ch_rd_en[c] = !fifo_wr_full & !ch_rd_empty[c] & (xfer_count != target). This is combinational from registered state. All other ch_rd_en bits are 0.
  - Each pop increments xfer_count.
  - On the pop that makes xfer_count equal target, move to DONE and pulse xfer_done for 1 cycle.
  - DONE: no pops. Go to IDLE when dma_us_busy=0; xfer_count clears on entry to IDLE.
  - dma_us_busy falling while in XFER: abort to IDLE, no xfer_done. Words already popped are still written.
- Write path: fifo_wr_en and fifo_wr_din are registered, 1 cycle after the pop; din = ch_rd_data[c] at pop time. Sustained rate is 1 word per cycle.
- Write hold: when no pop occurs, fifo_wr_en=0 and fifo_wr_din holds its value.
- Active indication: ch_rd_dma[i] = (state != IDLE) & (active_ch == i).
- Data interrupt: ch_irq[i] is registered = ch_enable[i] & ch_valid[i] & !ch_ds_mode[i] & int_en_data[i].
- Timeout counter (per channel): increments while ch_enable & !ch_valid & int_en_tout & !ch_ds_mode. It saturates at TOUT_VAL and clears whenever that condition is false.
- Timeout interrupt: ch_tout_irq[i] is registered = (cnt == TOUT_VAL) & ch_enable & !ch_ds_mode & int_en_tout. It stays high while saturated.
- Combined timeout: tout_all_irq = int_en_tout_all & AND over i of (!int_en_tout[i] | ch_tout_irq[i]). This output is combinational.
- Reset mid-transfer: asynchronous return to IDLE; nothing is written after reset asserts.

Decomposition:
- Package us_dma_pkg holds:
  - the state enum (IDLE/XFER/DONE);
  - PA_TAG_MSB=31 and PA_TAG_LSB=28;
  - a log2 function for WB.
- Sub-module ch_timeout_irq holds the per-channel counter plus the ch_irq and ch_tout_irq registers. It is instantiated NUM_CH times via generate.

Test Plan:
- Bench settings for all scenarios: NUM_CH=4, DATA_W=64, TOUT_VAL=16.
- Tag 2, dmasize[1]=64, FIFO 1 holds 8 words, full=0 -> 8 pops on consecutive cycles. fifo_wr_en=1 for 8 cycles starting 1 cycle after the first pop; data matches in order. xfer_done pulses once. ch_rd_dma=4'b0010 until busy drops.
- Same transfer with fifo_wr_full=1 for cycles 3-6 and FIFO 1 empty for 2 cycles -> no pops while stalled, total still 8, no duplicate or lost word.
- Tag 5, tag 0, and tag 3 with ch_ds_mode[2]=1 -> ch_rd_en stays 0 and the FSM stays in IDLE.
- dmasize=70 -> exactly 8 words; dmasize=0 -> immediate xfer_done, no pops.
- dma_us_busy drops after 3 of 8 pops -> return to IDLE, no xfer_done. A following transfer on tag 1 starts from xfer_count=0.
- Channel 0 enabled, ch_valid=0, int_en_tout[0]=1 -> ch_tout_irq[0] rises 17 cycles after the condition starts (16 counts plus 1 register stage) and clears when ch_valid=1. With int_en_tout=4'b0001 and int_en_tout_all=1, tout_all_irq follows ch_tout_irq[0].

Source files
------------

// File: rtl/us_dma_pkg.sv
// Shared types and constants for the upstream DMA channel mux.
package us_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } us_state_e;

  // Channel tag location inside the upstream DMA physical address.
  localparam int PA_TAG_MSB = 31;
  localparam int PA_TAG_LSB = 28;
  localparam int TAG_W      = PA_TAG_MSB - PA_TAG_LSB + 1;

  // Ceiling log2, used to turn a byte count into a word count.
  function automatic int log2_fn(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/us_dma_chan_mux_if.sv
// Data-path bundle: channel FIFO read side plus the shared PCIe write FIFO.
interface us_dma_chan_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64
);

  logic [NUM_CH*DATA_W-1:0] ch_rd_data;
  logic [NUM_CH-1:0]        ch_rd_empty;
  logic [NUM_CH-1:0]        ch_rd_en;
  logic [NUM_CH-1:0]        ch_rd_dma;
  logic                     fifo_wr_full;
  logic                     fifo_wr_en;
  logic [DATA_W-1:0]        fifo_wr_din;

  // The mux side: pops channel FIFOs and pushes the PCIe FIFO.
  modport master (
    input  ch_rd_data, ch_rd_empty, fifo_wr_full,
    output ch_rd_en, ch_rd_dma, fifo_wr_en, fifo_wr_din
  );

  // The FIFO side: supplies channel data and accepts PCIe writes.
  modport slave (
    output ch_rd_data, ch_rd_empty, fifo_wr_full,
    input  ch_rd_en, ch_rd_dma, fifo_wr_en, fifo_wr_din
  );

endinterface

// File: rtl/ch_timeout_irq.sv
// Per-channel data-ready interrupt and saturating no-data timeout interrupt.
module ch_timeout_irq #(
  parameter int TOUT_VAL = 250_000_000
) (
  input  logic user_clk,
  input  logic sys_rst,
  input  logic ch_enable,
  input  logic ch_ds_mode,
  input  logic ch_valid,
  input  logic int_en_data,
  input  logic int_en_tout,
  output logic ch_irq,
  output logic ch_tout_irq
);

  localparam int               CNT_W    = $clog2(TOUT_VAL + 1);
  localparam logic [CNT_W-1:0] TOUT_CNT = CNT_W'(TOUT_VAL);

  logic [CNT_W-1:0] cnt;
  logic             waiting;

  assign waiting = ch_enable & !ch_valid & int_en_tout & !ch_ds_mode;

  // Count idle cycles while the channel waits for data; saturate at the threshold.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge user_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (!waiting) begin
      cnt <= '0;
    end else if (cnt != TOUT_CNT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Register both interrupt lines so they are glitch-free at the host interface.
  always_ff @(posedge user_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ch_irq      <= 1'b0;
      ch_tout_irq <= 1'b0;
    end else begin
      ch_irq      <= ch_enable & ch_valid & !ch_ds_mode & int_en_data;
      ch_tout_irq <= (cnt == TOUT_CNT) & ch_enable & !ch_ds_mode & int_en_tout;
    end
  end

endmodule

// File: rtl/us_dma_chan_mux.sv
// Upstream DMA mux: moves a programmed byte count from the tagged channel
// FIFO into the shared PCIe write FIFO, plus per-channel interrupts.
module us_dma_chan_mux
  import us_dma_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 64,
  parameter int TOUT_VAL = 250_000_000,
  parameter int CH_W     = 4
) (
  input  logic                user_clk,
  input  logic                sys_rst,
  input  logic                dma_us_busy,
  input  logic [31:0]         dma_us_pa,
  input  logic [NUM_CH*32-1:0] ch_dmasize,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [NUM_CH-1:0]   ch_ds_mode,
  input  logic [NUM_CH-1:0]   ch_valid,
  input  logic [NUM_CH-1:0]   int_en_data,
  input  logic [NUM_CH-1:0]   int_en_tout,
  input  logic                int_en_tout_all,
  us_dma_chan_mux_if.master   bus,
  output logic [NUM_CH-1:0]   ch_irq,
  output logic [NUM_CH-1:0]   ch_tout_irq,
  output logic                any_irq,
  output logic                tout_all_irq,
  output logic [CH_W-1:0]     active_ch,
  output logic [31:0]         xfer_count,
  output logic                xfer_done
);

  localparam int WB_SHIFT = log2_fn(DATA_W / 8);

  us_state_e         state;
  logic [CH_W-1:0]   act_q;
  logic [31:0]       target_q;
  logic [31:0]       count_q;
  logic              done_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_din_q;

  logic [TAG_W-1:0]  tag;
  logic              tag_hit;
  logic [CH_W-1:0]   tag_idx;
  logic [31:0]       tag_target;
  logic [DATA_W-1:0] sel_data;
  logic              sel_empty;
  logic              pop;
  logic [NUM_CH-1:0] rd_en;
  logic [NUM_CH-1:0] rd_dma;
  logic              unused_pa;

  assign tag       = dma_us_pa[PA_TAG_MSB:PA_TAG_LSB];
  assign unused_pa = ^dma_us_pa[PA_TAG_LSB-1:0];

  // Decode the address tag into a channel index and its word target; tag 0,
  // out-of-range tags and downstream-mode channels never hit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tag_hit    = 1'b0;
    tag_idx    = '0;
    tag_target = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tag == TAG_W'(i + 1) && !ch_ds_mode[i]) begin
        tag_hit    = 1'b1;
        tag_idx    = CH_W'(i);
        tag_target = ch_dmasize[32*i +: 32] >> WB_SHIFT;
      end
    end
  end

  // Steer the latched channel's FIFO head onto a single data/empty pair.
  always_comb begin
    sel_data  = '0;
    sel_empty = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act_q == CH_W'(i)) begin
        sel_data  = bus.ch_rd_data[i*DATA_W +: DATA_W];
        sel_empty = bus.ch_rd_empty[i];
      end
    end
  end

  assign pop = (state == S_XFER) & !bus.fifo_wr_full & !sel_empty & (count_q != target_q);

  // Pop strobe and ownership flag for the active channel only.
  always_comb begin
    rd_en  = '0;
    rd_dma = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_en[i]  = pop & (act_q == CH_W'(i));
      rd_dma[i] = (state != S_IDLE) & (act_q == CH_W'(i));
    end
  end

  // Transfer FSM with registered write path; a popped word is always written
  // on the following cycle, even if the transfer is aborted on that edge.
  always_ff @(posedge user_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      act_q    <= '0;
      target_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_din_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= pop;
      if (pop) wr_din_q <= sel_data;
      case (state)
        S_IDLE: begin
          if (dma_us_busy && tag_hit) begin
            act_q    <= tag_idx;
            target_q <= tag_target;
            count_q  <= '0;
            if (tag_target == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (!dma_us_busy) begin
            state   <= S_IDLE;
            count_q <= '0;
          end else if (pop) begin
            count_q <= count_q + 32'd1;
            if (count_q + 32'd1 == target_q) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!dma_us_busy) begin
            state   <= S_IDLE;
            count_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ch_rd_en    = rd_en;
  assign bus.ch_rd_dma   = rd_dma;
  assign bus.fifo_wr_en  = wr_en_q;
  assign bus.fifo_wr_din = wr_din_q;
  assign active_ch       = act_q;
  assign xfer_count      = count_q;
  assign xfer_done       = done_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_timeout_irq #(
      .TOUT_VAL (TOUT_VAL)
    ) u_tout (
      .user_clk    (user_clk),
      .sys_rst     (sys_rst),
      .ch_enable   (ch_enable[g]),
      .ch_ds_mode  (ch_ds_mode[g]),
      .ch_valid    (ch_valid[g]),
      .int_en_data (int_en_data[g]),
      .int_en_tout (int_en_tout[g]),
      .ch_irq      (ch_irq[g]),
      .ch_tout_irq (ch_tout_irq[g])
    );
  end

  assign any_irq      = |ch_irq;
  assign tout_all_irq = int_en_tout_all & (&(~int_en_tout | ch_tout_irq));

endmodule

// File: tb/tb_us_dma_chan_mux.sv
// Directed bench for us_dma_chan_mux with FWFT channel FIFO models and a
// write-data scoreboard.
module tb_us_dma_chan_mux;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 64;
  localparam int TOUT_VAL = 16;
  localparam int CH_W     = 4;

  logic                 user_clk = 1'b0;
  logic                 sys_rst  = 1'b1;
  logic                 dma_us_busy = 1'b0;
  logic [31:0]          dma_us_pa = '0;
  logic [NUM_CH*32-1:0] ch_dmasize = '0;
  logic [NUM_CH-1:0]    ch_enable = '0;
  logic [NUM_CH-1:0]    ch_ds_mode = '0;
  logic [NUM_CH-1:0]    ch_valid = '0;
  logic [NUM_CH-1:0]    int_en_data = '0;
  logic [NUM_CH-1:0]    int_en_tout = '0;
  logic                 int_en_tout_all = 1'b0;
  logic [NUM_CH-1:0]    ch_irq;
  logic [NUM_CH-1:0]    ch_tout_irq;
  logic                 any_irq;
  logic                 tout_all_irq;
  logic [CH_W-1:0]      active_ch;
  logic [31:0]          xfer_count;
  logic                 xfer_done;

  logic                 wr_full = 1'b0;
  logic [NUM_CH-1:0]    hold_empty = '0;

  us_dma_chan_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  us_dma_chan_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TOUT_VAL(TOUT_VAL), .CH_W(CH_W)
  ) dut (
    .user_clk        (user_clk),
    .sys_rst         (sys_rst),
    .dma_us_busy     (dma_us_busy),
    .dma_us_pa       (dma_us_pa),
    .ch_dmasize      (ch_dmasize),
    .ch_enable       (ch_enable),
    .ch_ds_mode      (ch_ds_mode),
    .ch_valid        (ch_valid),
    .int_en_data     (int_en_data),
    .int_en_tout     (int_en_tout),
    .int_en_tout_all (int_en_tout_all),
    .bus             (bus),
    .ch_irq          (ch_irq),
    .ch_tout_irq     (ch_tout_irq),
    .any_irq         (any_irq),
    .tout_all_irq    (tout_all_irq),
    .active_ch       (active_ch),
    .xfer_count      (xfer_count),
    .xfer_done       (xfer_done)
  );

  always #5 user_clk = ~user_clk;

  // FWFT channel FIFO models: the initial block appends, the clocked block pops.
  logic [DATA_W-1:0] mem [NUM_CH][256];
  logic [7:0]        wr_ptr [NUM_CH] = '{default: 8'd0};
  logic [7:0]        rd_ptr [NUM_CH] = '{default: 8'd0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    assign bus.ch_rd_data[g*DATA_W +: DATA_W] = mem[g][rd_ptr[g]];
    assign bus.ch_rd_empty[g] = (rd_ptr[g] == wr_ptr[g]) | hold_empty[g];
  end
  assign bus.fifo_wr_full = wr_full;

  always @(posedge user_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 8'd1;
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_cnt       = 0;
  int done_cnt     = 0;
  logic [DATA_W-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every PCIe write must match the next expected word in order.
  always @(negedge user_clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      wr_cnt++;
      check("wr_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) check("wr_data", bus.fifo_wr_din, sb.pop_front());
    end
    if (xfer_done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge user_clk);
  endtask

  // Append n words to channel ch; the first n_exp are expected on the PCIe side.
  task automatic load(input int ch, input int n, input int n_exp);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {8'(ch), 8'(k), 16'(wr_ptr[ch]), 32'($urandom)};
      mem[ch][wr_ptr[ch]] = w;
      wr_ptr[ch] = wr_ptr[ch] + 8'd1;
      if (k < n_exp) sb.push_back(w);
    end
  endtask

  task automatic flush(input int ch);
    wr_ptr[ch] = rd_ptr[ch];
  endtask

  task automatic start(input int tag);
    dma_us_pa   = {4'(tag), 28'h0};
    dma_us_busy = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (xfer_done !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check(tag, 64'(xfer_done), 64'd1);
  endtask

  initial begin
    int wr0, dn0;
    logic [7:0] rp0;
    bit seen_done;
    int bad_tag [3];
    logic [NUM_CH-1:0] bad_ds [3];

    // Reset state.
    tick(2);
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("rst_rd_en", 64'(bus.ch_rd_en), 64'd0);
    check("rst_rd_dma", 64'(bus.ch_rd_dma), 64'd0);
    check("rst_done", 64'(xfer_done), 64'd0);
    check("rst_active", 64'(active_ch), 64'd0);
    check("rst_count", 64'(xfer_count), 64'd0);
    check("rst_irq", 64'({ch_irq, ch_tout_irq, any_irq, tout_all_irq}), 64'd0);
    sys_rst = 1'b0;
    tick(2);

    // Straight 8-word transfer on tag 2 (channel 1).
    ch_dmasize[32*1 +: 32] = 32'd64;
    load(1, 8, 8);
    wr0 = wr_cnt; dn0 = done_cnt;
    start(2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("s1_rd_en", 64'(bus.ch_rd_en), 64'b0010);
      check("s1_wr_en", 64'(bus.fifo_wr_en), 64'(k >= 2));
    end
    tick();
    check("s1_rd_en_end", 64'(bus.ch_rd_en), 64'd0);
    check("s1_done", 64'(xfer_done), 64'd1);
    check("s1_last_wr", 64'(bus.fifo_wr_en), 64'd1);
    tick();
    check("s1_done_pulse", 64'(xfer_done), 64'd0);
    check("s1_count", 64'(xfer_count), 64'd8);
    check("s1_dma_hold", 64'(bus.ch_rd_dma), 64'b0010);
    dma_us_busy = 1'b0;
    tick();
    check("s1_dma_idle", 64'(bus.ch_rd_dma), 64'd0);
    check("s1_count_clr", 64'(xfer_count), 64'd0);
    tick();
    check("s1_writes", 64'(wr_cnt - wr0), 64'd8);
    check("s1_done_cnt", 64'(done_cnt - dn0), 64'd1);

    // Same transfer with back-pressure and a starved FIFO; two extra words stay behind.
    load(1, 10, 8);
    wr0 = wr_cnt; dn0 = done_cnt; rp0 = rd_ptr[1];
    seen_done = 1'b0;
    start(2);
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      tick();
      if (xfer_done === 1'b1) seen_done = 1'b1;
      wr_full       = (c >= 3 && c <= 6);
      hold_empty[1] = (c == 9 || c == 10);
      #1;
      if (wr_full || hold_empty[1]) check("s2_stall_no_pop", 64'(bus.ch_rd_en), 64'd0);
    end
    wr_full = 1'b0; hold_empty = '0;
    check("s2_done_seen", 64'(seen_done), 64'd1);
    dma_us_busy = 1'b0;
    tick(3);
    check("s2_writes", 64'(wr_cnt - wr0), 64'd8);
    check("s2_pops", 64'(8'(rd_ptr[1] - rp0)), 64'd8);
    check("s2_done_cnt", 64'(done_cnt - dn0), 64'd1);
    check("s2_sb_empty", 64'(sb.size()), 64'd0);
    flush(1);

    // Tags that must be ignored: out of range, zero, downstream-mode channel.
    bad_tag = '{5, 0, 3};
    bad_ds  = '{4'b0000, 4'b0000, 4'b0100};
    for (int i = 0; i < NUM_CH; i++) ch_dmasize[32*i +: 32] = 32'd64;
    for (int i = 0; i < NUM_CH; i++) load(i, 1, 0);
    for (int t = 0; t < 3; t++) begin
      ch_ds_mode = bad_ds[t];
      start(bad_tag[t]);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("s3_no_pop", 64'(bus.ch_rd_en), 64'd0);
        check("s3_idle", 64'(bus.ch_rd_dma), 64'd0);
      end
      dma_us_busy = 1'b0;
      tick();
    end
    ch_ds_mode = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      check("s3_fifo_untouched", 64'(8'(wr_ptr[i] - rd_ptr[i])), 64'd1);
      flush(i);
    end

    // 70 bytes truncate to 8 whole words on tag 1.
    ch_dmasize[32*0 +: 32] = 32'd70;
    load(0, 10, 8);
    wr0 = wr_cnt; dn0 = done_cnt;
    start(1);
    wait_done("s4_done_70", 40);
    dma_us_busy = 1'b0;
    tick(3);
    check("s4_writes_70", 64'(wr_cnt - wr0), 64'd8);
    check("s4_done_cnt_70", 64'(done_cnt - dn0), 64'd1);
    flush(0);

    // Zero-size transfer on tag 4: immediate completion, no pops.
    ch_dmasize[32*3 +: 32] = 32'd0;
    load(3, 2, 0);
    rp0 = rd_ptr[3];
    start(4);
    tick();
    check("s4_zero_done", 64'(xfer_done), 64'd1);
    check("s4_zero_rd_en", 64'(bus.ch_rd_en), 64'd0);
    check("s4_zero_dma", 64'(bus.ch_rd_dma), 64'b1000);
    tick();
    check("s4_zero_pulse", 64'(xfer_done), 64'd0);
    dma_us_busy = 1'b0;
    tick(2);
    check("s4_zero_no_pop", 64'(8'(rd_ptr[3] - rp0)), 64'd0);
    flush(3);

    // Abort after three pops; those three are still written, no completion.
    ch_dmasize[32*1 +: 32] = 32'd64;
    load(1, 8, 3);
    wr0 = wr_cnt; dn0 = done_cnt;
    start(2);
    tick(3);
    dma_us_busy = 1'b0;
    tick();
    check("s5_abort_idle", 64'(bus.ch_rd_dma), 64'd0);
    check("s5_abort_rd_en", 64'(bus.ch_rd_en), 64'd0);
    check("s5_abort_count", 64'(xfer_count), 64'd0);
    tick(2);
    check("s5_abort_writes", 64'(wr_cnt - wr0), 64'd3);
    check("s5_abort_no_done", 64'(done_cnt - dn0), 64'd0);
    flush(1);

    // Follow-up transfer on tag 1 starts from a clean count.
    ch_dmasize[32*0 +: 32] = 32'd16;
    load(0, 2, 2);
    wr0 = wr_cnt;
    start(1);
    tick();
    check("s5_next_count", 64'(xfer_count), 64'd0);
    check("s5_next_active", 64'(active_ch), 64'd0);
    wait_done("s5_next_done", 20);
    dma_us_busy = 1'b0;
    tick(3);
    check("s5_next_writes", 64'(wr_cnt - wr0), 64'd2);

    // Timeout interrupt on channel 0 and the combined timeout line.
    int_en_tout = 4'b0001; int_en_tout_all = 1'b1;
    ch_enable[0] = 1'b1; ch_valid[0] = 1'b0;
    tick(16);
    check("s6_tout_early", 64'(ch_tout_irq), 64'd0);
    check("s6_all_early", 64'(tout_all_irq), 64'd0);
    tick();
    check("s6_tout_rise", 64'(ch_tout_irq), 64'b0001);
    check("s6_all_rise", 64'(tout_all_irq), 64'd1);
    int_en_tout_all = 1'b0;
    #1;
    check("s6_all_gated", 64'(tout_all_irq), 64'd0);
    int_en_tout_all = 1'b1;
    ch_valid[0] = 1'b1; int_en_data[0] = 1'b1;
    tick();
    check("s6_data_irq", 64'(ch_irq), 64'b0001);
    check("s6_any_irq", 64'(any_irq), 64'd1);
    tick();
    check("s6_tout_clear", 64'(ch_tout_irq), 64'd0);
    check("s6_all_clear", 64'(tout_all_irq), 64'd0);
    ch_enable = '0; int_en_data = '0; int_en_tout = '0; int_en_tout_all = 1'b0;
    tick(2);

    // Reset in the middle of a transfer: nothing written afterwards.
    load(1, 8, 2);
    wr0 = wr_cnt; rp0 = rd_ptr[1];
    start(2);
    tick(3);
    #2;
    sys_rst = 1'b1;
    #1;
    check("s7_rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("s7_rst_rd_en", 64'(bus.ch_rd_en), 64'd0);
    check("s7_rst_dma", 64'(bus.ch_rd_dma), 64'd0);
    dma_us_busy = 1'b0;
    tick(3);
    check("s7_rst_writes", 64'(wr_cnt - wr0), 64'd2);
    check("s7_rst_pops", 64'(8'(rd_ptr[1] - rp0)), 64'd2);
    sys_rst = 1'b0;
    flush(1);
    tick(2);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
